// File: rtl/subtractor_16bit_seq.sv
// subtractor_16bit_seq
//   Sequential 16-bit subtractor computing diff = a - b - b_in, one 4-bit nibble per clock.
//   An operation is accepted in IDLE, takes four CALC cycles (LSB nibble first), and the
//   result is then held in DONE until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b, b_in are valid this cycle
//   in_ready   block can accept operands (IDLE only)
//   a, b       16-bit unsigned minuend / subtrahend
//   b_in       borrow in, subtracted at bit 0
//   diff       result a - b - b_in, modulo 2^16
//   b_out      borrow out of bit 15
//   zero       diff == 0
//   out_valid  diff, b_out and zero hold a completed result (DONE only)
//   out_ready  consumer accepts the result this cycle

module subtractor_16bit_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        b_in,
    output logic [15:0] diff,
    output logic        b_out,
    output logic        zero,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  nib_q, nib_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        borrow_q, borrow_d;
    logic [15:0] diff_q, diff_d;
    logic        b_out_q, b_out_d;
    logic        zero_q, zero_d;

    logic [3:0]  nib_lsb;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [4:0]  step;

    // Bit offset of the nibble handled this cycle.
    assign nib_lsb = {nib_q, 2'b00};
    assign nib_a   = a_q[nib_lsb +: 4];
    assign nib_b   = b_q[nib_lsb +: 4];
    // 5-bit subtraction: bit 4 is set exactly when the nibble result went negative.
    assign step    = {1'b0, nib_a} - {1'b0, nib_b} - {4'b0000, borrow_q};

    always_comb begin
        state_d  = state_q;
        nib_d    = nib_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        zero_d   = zero_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = b_in;
                    nib_d    = 2'd0;
                    diff_d   = 16'h0000;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                diff_d[nib_lsb +: 4] = step[3:0];
                borrow_d             = step[4];
                nib_d                = nib_q + 2'd1;
                if (nib_q == 2'd3) begin
                    b_out_d = step[4];
                    // Uses the fully assembled result including the nibble written above.
                    zero_d  = (diff_d == 16'h0000);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            nib_q    <= 2'd0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            borrow_q <= 1'b0;
            diff_q   <= 16'h0000;
            b_out_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nib_q    <= nib_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign diff      = diff_q;
    assign b_out     = b_out_q;
    assign zero      = zero_q;

endmodule

// File: doc/subtractor_16bit_seq.md
SUBTRACTOR_16BIT_SEQ -- requirements
Module: subtractor_16bit_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands a, b, b_in are valid this cycle.
REQ-005 in_ready  output  1  block can accept operands this cycle.
REQ-006 a  input  16  minuend, unsigned.
REQ-007 b  input  16  subtrahend, unsigned.
REQ-008 b_in  input  1  borrow in, subtracted at bit 0.
REQ-009 diff  output  16  result a - b - b_in, modulo 2^16.
REQ-010 b_out  output  1  borrow out of bit 15.
REQ-011 zero  output  1  diff == 16'h0000.
REQ-012 out_valid  output  1  diff, b_out and zero hold a completed result.
REQ-013 out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-014 The block SHALL implement states IDLE, CALC, DONE, with a 2-bit nibble counter used in CALC.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept: on an edge with in_valid=1 in IDLE, the block SHALL latch a, b, b_in, clear the nibble counter and diff, and go to CALC.
REQ-017 in_valid in CALC or DONE SHALL be ignored; operand inputs changing after acceptance SHALL NOT affect the result.
REQ-018 CALC step k (k=0..3, one per edge) SHALL compute diff[4k+3:4k] = a[4k+3:4k] - b[4k+3:4k] - borrow, where borrow is b_in for k=0 and the borrow from step k-1 otherwise.
REQ-019 On the edge of step k=3, the block SHALL load b_out with the final borrow, load zero with (full diff == 0), and go to DONE.
REQ-020 Latency: with accept on edge T, out_valid SHALL be 1 after edge T+4, i.e. exactly 4 cycles after acceptance.
REQ-021 In DONE, diff, b_out and zero SHALL be held stable while out_ready=0, for any number of cycles.
REQ-022 On an edge in DONE with out_ready=1, the block SHALL go to IDLE; in_ready SHALL be 1 in the following cycle; diff, b_out and zero SHALL hold their last values until the next acceptance.
REQ-023 The block SHALL NOT overlap operations: at most one operation is in flight, and the minimum accept-to-accept period is 6 cycles.
REQ-024 b_out SHALL be 1 iff the unsigned value a < b + b_in; this includes the case a=b with b_in=1.
REQ-025 out_ready outside DONE SHALL have no effect.

Reset
REQ-026 While rst_n=0, independent of clk, the block SHALL hold state at IDLE, the nibble counter at 0, diff=16'h0000, b_out=0, zero=0, out_valid=0 and in_ready=1.
REQ-027 If reset is asserted in CALC or DONE, the block SHALL abort the operation and discard the result.
REQ-028 After rst_n deasserts, the first rising edge SHALL be able to accept operands.

Verification
REQ-029 a=16'h1234, b=16'h0234, b_in=0 -> diff=16'h1000, b_out=0, zero=0; out_valid rises exactly 4 cycles after accept.
REQ-030 a=16'h0000, b=16'h0001, b_in=0 -> diff=16'hFFFF, b_out=1; this checks the borrow ripples across all nibbles.
REQ-031 a=16'h8000, b=16'h7FFF, b_in=1 -> diff=16'h0000, b_out=0, zero=1; a=b=16'hFFFF with b_in=1 -> diff=16'hFFFF, b_out=1.
REQ-032 Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not accepted; then out_ready=1 -> IDLE next cycle and new operands accepted on the following edge.
REQ-033 Assert rst_n=0 at nibble step 2 of an operation -> outputs immediately reset to the values in REQ-026; after release, a=16'h0005, b=16'h0003, b_in=0 -> diff=16'h0002, b_out=0.
REQ-034 Random back-to-back operations against a reference model of a - b - b_in -> all diff, b_out and zero values match; count of accepts equals count of completed out_valid/out_ready handshakes.
